// File: rtl/argmax_stream_classifier.sv
// Streaming argmax classifier: consumes one class score per cycle, tracks the
// best score, its class index and the runner-up, then presents the winner, the
// best-vs-runner-up margin and a framing-error flag through a valid/ready port.
//
// state | meaning
// ------+---------------------------------------------------------------
// ACC   | accepting scores of the current frame, in_ready=1
// HOLD  | result presented on out_*, waiting for out_ready, in_ready=0
module argmax_stream_classifier #(
    parameter int DATA_W      = 26,
    parameter int NUM_CLASSES = 10,
    parameter int IDX_W       = 4,
    parameter bit SIGNED      = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [IDX_W-1:0]  out_idx,
    output logic [DATA_W-1:0] out_max,
    output logic [DATA_W:0]   out_margin,
    output logic              out_err
);

    // Smallest representable score; seeds the runner-up at the start of a frame
    // so a single-sample frame reports margin = best - MIN.
    localparam logic [DATA_W-1:0] MIN_VAL  = SIGNED ? {1'b1, {(DATA_W-1){1'b0}}}
                                                    : {DATA_W{1'b0}};
    localparam logic [IDX_W-1:0]  LAST_CNT = IDX_W'(NUM_CLASSES - 1);
    // All-ones index never names a real class, so it marks "no result yet".
    localparam logic [IDX_W-1:0]  IDX_NONE = {IDX_W{1'b1}};

    typedef enum logic [0:0] {
        ST_ACC  = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [IDX_W-1:0]    count_q, count_d;
    logic [DATA_W-1:0]   best_q, best_d;
    logic [DATA_W-1:0]   second_q, second_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [IDX_W-1:0]    out_idx_q, out_idx_d;
    logic [DATA_W-1:0]   out_max_q, out_max_d;
    logic [DATA_W:0]     out_margin_q, out_margin_d;
    logic                out_err_q, out_err_d;

    logic [DATA_W-1:0]   upd_best;
    logic [DATA_W-1:0]   upd_second;
    logic [IDX_W-1:0]    upd_idx;
    logic [DATA_W:0]     upd_margin;
    logic                at_last_slot;
    logic                frame_end;
    logic                frame_err;

    // Strict greater-than in the configured number interpretation.
    function automatic logic score_gt(input logic [DATA_W-1:0] a,
                                      input logic [DATA_W-1:0] b);
        if (SIGNED) begin
            return $signed(a) > $signed(b);
        end else begin
            return a > b;
        end
    endfunction

    // Widen by one bit so best - second never overflows.
    function automatic logic [DATA_W:0] score_ext(input logic [DATA_W-1:0] a);
        if (SIGNED) begin
            return {a[DATA_W-1], a};
        end else begin
            return {1'b0, a};
        end
    endfunction

    // Tracker update for the sample on in_data; ties keep the incumbent so the
    // lowest index wins.
    always_comb begin
        upd_best   = best_q;
        upd_second = second_q;
        upd_idx    = idx_q;
        if (count_q == '0) begin
            upd_best   = in_data;
            upd_second = MIN_VAL;
            upd_idx    = '0;
        end else if (score_gt(in_data, best_q)) begin
            upd_second = best_q;
            upd_best   = in_data;
            upd_idx    = count_q;
        end else if (score_gt(in_data, second_q)) begin
            upd_second = in_data;
        end
    end

    // Frame termination and error classification for the current accept.
    always_comb begin
        upd_margin   = score_ext(upd_best) - score_ext(upd_second);
        at_last_slot = (count_q == LAST_CNT);
        frame_end    = in_last || at_last_slot;
        frame_err    = (in_last && (count_q < LAST_CNT)) || (!in_last && at_last_slot);
    end

    // Next-state and handshake outputs.
    always_comb begin
        state_d      = state_q;
        count_d      = count_q;
        best_d       = best_q;
        second_d     = second_q;
        idx_d        = idx_q;
        out_idx_d    = out_idx_q;
        out_max_d    = out_max_q;
        out_margin_d = out_margin_q;
        out_err_d    = out_err_q;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        case (state_q)
            ST_ACC: begin
                in_ready = !rst;
                if (in_valid && !rst) begin
                    best_d   = upd_best;
                    second_d = upd_second;
                    idx_d    = upd_idx;
                    count_d  = count_q + IDX_W'(1);
                    if (frame_end) begin
                        state_d      = ST_HOLD;
                        count_d      = '0;
                        out_idx_d    = upd_idx;
                        out_max_d    = upd_best;
                        out_margin_d = upd_margin;
                        out_err_d    = frame_err;
                    end
                end
            end
            ST_HOLD: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = ST_ACC;
                    count_d = '0;
                end
            end
            default: begin
                state_d = ST_ACC;
                count_d = '0;
            end
        endcase
    end

    // State and result registers; reset discards any partial frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_ACC;
            count_q      <= '0;
            best_q       <= '0;
            second_q     <= MIN_VAL;
            idx_q        <= '0;
            out_idx_q    <= IDX_NONE;
            out_max_q    <= '0;
            out_margin_q <= '0;
            out_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            best_q       <= best_d;
            second_q     <= second_d;
            idx_q        <= idx_d;
            out_idx_q    <= out_idx_d;
            out_max_q    <= out_max_d;
            out_margin_q <= out_margin_d;
            out_err_q    <= out_err_d;
        end
    end

    assign out_idx    = out_idx_q;
    assign out_max    = out_max_q;
    assign out_margin = out_margin_q;
    assign out_err    = out_err_q;

endmodule

// File: tb/tb_argmax_stream_classifier.sv
// Directed and randomised bench for argmax_stream_classifier: a signed and an
// unsigned instance share one input stream and one out_ready.
module tb_argmax_stream_classifier;

    localparam int DW = 26;
    localparam int NC = 10;
    localparam int IW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          in_last;
    logic          out_ready;

    logic          s_in_ready, s_out_valid, s_out_err;
    logic [IW-1:0] s_out_idx;
    logic [DW-1:0] s_out_max;
    logic [DW:0]   s_out_margin;
    logic          u_in_ready, u_out_valid, u_out_err;
    logic [IW-1:0] u_out_idx;
    logic [DW-1:0] u_out_max;
    logic [DW:0]   u_out_margin;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    argmax_stream_classifier #(.DATA_W(DW), .NUM_CLASSES(NC), .IDX_W(IW), .SIGNED(1'b1)) u_sgn (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(s_in_ready),
        .in_data(in_data), .in_last(in_last), .out_valid(s_out_valid),
        .out_ready(out_ready), .out_idx(s_out_idx), .out_max(s_out_max),
        .out_margin(s_out_margin), .out_err(s_out_err)
    );

    argmax_stream_classifier #(.DATA_W(DW), .NUM_CLASSES(NC), .IDX_W(IW), .SIGNED(1'b0)) u_uns (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(u_in_ready),
        .in_data(in_data), .in_last(in_last), .out_valid(u_out_valid),
        .out_ready(out_ready), .out_idx(u_out_idx), .out_max(u_out_max),
        .out_margin(u_out_margin), .out_err(u_out_err)
    );

    task automatic tick_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Present one beat from a negedge, wait for both instances to be ready,
    // let the next posedge take it, return at the following negedge.
    task automatic send(input logic [DW-1:0] d, input logic l);
        int guard;
        guard    = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        while (!(s_in_ready === 1'b1 && u_in_ready === 1'b1) && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 100) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: in_ready s=%b u=%b required 1", s_in_ready, u_in_ready);
        end
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic send_frame(input int v[NC], input int n, input bit with_last);
        for (int i = 0; i < n; i++) begin
            send(DW'(v[i]), with_last && (i == n - 1));
        end
    endtask

    task automatic wait_valid(input int budget);
        int g;
        g = 0;
        while (!(s_out_valid === 1'b1 && u_out_valid === 1'b1) && g < budget) begin
            @(negedge clk);
            g++;
        end
        if (g >= budget) begin
            checks++;
            errors++;
            $display("FAIL wait_valid_timeout: out_valid s=%b u=%b required 1", s_out_valid, u_out_valid);
        end
    endtask

    task automatic release_result();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b0;
        tick_n(3);
        checks++; if (s_out_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b expected 0", s_out_valid); end
        checks++; if (s_out_idx !== 4'hF) begin errors++; $display("FAIL rst_idx: got %0h expected f", s_out_idx); end
        checks++; if (s_out_max !== '0) begin errors++; $display("FAIL rst_max: got %0h expected 0", s_out_max); end
        checks++; if (s_out_margin !== '0) begin errors++; $display("FAIL rst_margin: got %0h expected 0", s_out_margin); end
        checks++; if (s_out_err !== 1'b0) begin errors++; $display("FAIL rst_err: got %b expected 0", s_out_err); end
        checks++; if (s_in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready: got %b expected 0", s_in_ready); end
        rst = 1'b0;
        tick_n(1);
        checks++; if (s_in_ready !== 1'b1) begin errors++; $display("FAIL post_rst_in_ready: got %b expected 1", s_in_ready); end
    endtask

    task automatic test_basic();
        int v[NC] = '{5, 3, 9, -2, 9, 0, 1, 7, 8, 4};
        send_frame(v, NC - 1, 1'b0);
        checks++; if (s_out_valid !== 1'b0) begin errors++; $display("FAIL basic_early_valid: got %b expected 0", s_out_valid); end
        send(DW'(v[NC-1]), 1'b1);
        checks++; if (s_out_valid !== 1'b1) begin errors++; $display("FAIL basic_latency: got %b expected 1", s_out_valid); end
        checks++; if (s_out_idx !== 4'd2) begin errors++; $display("FAIL basic_idx: got %0d expected 2", s_out_idx); end
        checks++; if (s_out_max !== 26'd9) begin errors++; $display("FAIL basic_max: got %0h expected 9", s_out_max); end
        checks++; if (s_out_margin !== 27'd0) begin errors++; $display("FAIL basic_margin: got %0h expected 0", s_out_margin); end
        checks++; if (s_out_err !== 1'b0) begin errors++; $display("FAIL basic_err: got %b expected 0", s_out_err); end
        checks++; if (u_out_idx !== 4'd3) begin errors++; $display("FAIL basic_u_idx: got %0d expected 3", u_out_idx); end
        checks++; if (u_out_max !== 26'h3FFFFFE) begin errors++; $display("FAIL basic_u_max: got %0h expected 3fffffe", u_out_max); end
        checks++; if (u_out_margin !== 27'h3FFFFF5) begin errors++; $display("FAIL basic_u_margin: got %0h expected 3fffff5", u_out_margin); end
        release_result();
        checks++; if (s_out_valid !== 1'b0) begin errors++; $display("FAIL basic_valid_drop: got %b expected 0", s_out_valid); end
    endtask

    task automatic test_signed_unsigned();
        int v[NC] = '{-100, -100, -100, -100, -100, -100, -1, -100, -100, -100};
        int w[NC] = '{1, -1, 2, 0, 0, 0, 0, 0, 0, 0};
        send_frame(v, NC, 1'b1);
        wait_valid(5);
        checks++; if (s_out_idx !== 4'd6) begin errors++; $display("FAIL sgn_idx: got %0d expected 6", s_out_idx); end
        checks++; if (s_out_max !== 26'h3FFFFFF) begin errors++; $display("FAIL sgn_max: got %0h expected 3ffffff", s_out_max); end
        checks++; if (s_out_margin !== 27'd99) begin errors++; $display("FAIL sgn_margin: got %0d expected 99", s_out_margin); end
        checks++; if (u_out_idx !== 4'd6) begin errors++; $display("FAIL uns_idx: got %0d expected 6", u_out_idx); end
        checks++; if (u_out_margin !== 27'd99) begin errors++; $display("FAIL uns_margin: got %0d expected 99", u_out_margin); end
        release_result();
        send_frame(w, 3, 1'b1);
        wait_valid(5);
        checks++; if (s_out_idx !== 4'd2) begin errors++; $display("FAIL mix_s_idx: got %0d expected 2", s_out_idx); end
        checks++; if (s_out_margin !== 27'd1) begin errors++; $display("FAIL mix_s_margin: got %0h expected 1", s_out_margin); end
        checks++; if (u_out_idx !== 4'd1) begin errors++; $display("FAIL mix_u_idx: got %0d expected 1", u_out_idx); end
        checks++; if (u_out_max !== 26'h3FFFFFF) begin errors++; $display("FAIL mix_u_max: got %0h expected 3ffffff", u_out_max); end
        checks++; if (u_out_margin !== 27'h3FFFFFD) begin errors++; $display("FAIL mix_u_margin: got %0h expected 3fffffd", u_out_margin); end
        checks++; if (u_out_err !== 1'b1) begin errors++; $display("FAIL mix_u_err: got %b expected 1", u_out_err); end
        release_result();
    endtask

    task automatic test_framing();
        int a[NC] = '{1, 2, 3, 4, 0, 0, 0, 0, 0, 0};
        int b[NC] = '{10, 11, 12, 13, 14, 15, 16, 17, 18, 19};
        int c[NC] = '{5, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        send_frame(a, 4, 1'b1);
        checks++; if (s_out_valid !== 1'b1) begin errors++; $display("FAIL short_valid: got %b expected 1", s_out_valid); end
        checks++; if (s_out_idx !== 4'd3) begin errors++; $display("FAIL short_idx: got %0d expected 3", s_out_idx); end
        checks++; if (s_out_max !== 26'd4) begin errors++; $display("FAIL short_max: got %0h expected 4", s_out_max); end
        checks++; if (s_out_margin !== 27'd1) begin errors++; $display("FAIL short_margin: got %0h expected 1", s_out_margin); end
        checks++; if (s_out_err !== 1'b1) begin errors++; $display("FAIL short_err: got %b expected 1", s_out_err); end
        release_result();
        send_frame(b, NC, 1'b0);
        checks++; if (s_out_valid !== 1'b1) begin errors++; $display("FAIL nolast_valid: got %b expected 1", s_out_valid); end
        checks++; if (s_out_idx !== 4'd9) begin errors++; $display("FAIL nolast_idx: got %0d expected 9", s_out_idx); end
        checks++; if (s_out_max !== 26'd19) begin errors++; $display("FAIL nolast_max: got %0d expected 19", s_out_max); end
        checks++; if (s_out_err !== 1'b1) begin errors++; $display("FAIL nolast_err: got %b expected 1", s_out_err); end
        release_result();
        send_frame(c, 1, 1'b1);
        checks++; if (s_out_margin !== 27'd33554437) begin errors++; $display("FAIL one_s_margin: got %0d expected 33554437", s_out_margin); end
        checks++; if (u_out_margin !== 27'd5) begin errors++; $display("FAIL one_u_margin: got %0d expected 5", u_out_margin); end
        checks++; if (s_out_idx !== 4'd0) begin errors++; $display("FAIL one_idx: got %0d expected 0", s_out_idx); end
        release_result();
    endtask

    task automatic test_backpressure();
        int v[NC] = '{5, 3, 9, -2, 9, 0, 1, 7, 8, 4};
        int w[NC] = '{7, 1, 2, 3, 4, 5, 6, 0, 0, 0};
        send_frame(v, NC, 1'b1);
        in_valid = 1'b1; in_data = 26'd7; in_last = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            checks++;
            if (s_out_valid !== 1'b1 || s_out_idx !== 4'd2 || s_out_max !== 26'd9 || s_in_ready !== 1'b0) begin
                errors++;
                $display("FAIL hold_stable: cyc %0d valid=%b idx=%0d max=%0h in_ready=%b expected 1/2/9/0",
                         i, s_out_valid, s_out_idx, s_out_max, s_in_ready);
            end
        end
        release_result();
        checks++; if (s_out_valid !== 1'b0) begin errors++; $display("FAIL hs_valid: got %b expected 0", s_out_valid); end
        checks++; if (s_in_ready !== 1'b1) begin errors++; $display("FAIL hs_in_ready: got %b expected 1", s_in_ready); end
        send_frame(w, NC, 1'b1);
        checks++; if (s_out_idx !== 4'd0) begin errors++; $display("FAIL bp_idx: got %0d expected 0", s_out_idx); end
        checks++; if (s_out_max !== 26'd7) begin errors++; $display("FAIL bp_max: got %0d expected 7", s_out_max); end
        checks++; if (s_out_margin !== 27'd1) begin errors++; $display("FAIL bp_margin: got %0d expected 1", s_out_margin); end
        checks++; if (s_out_err !== 1'b0) begin errors++; $display("FAIL bp_err: got %b expected 0", s_out_err); end
        release_result();
    endtask

    task automatic test_reset_midframe();
        int big[NC] = '{50, 50, 50, 50, 50, 0, 0, 0, 0, 0};
        int v[NC]   = '{5, 3, 9, -2, 9, 0, 1, 7, 8, 4};
        send_frame(big, 5, 1'b0);
        rst = 1'b1;
        tick_n(1);
        checks++; if (s_out_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid: got %b expected 0", s_out_valid); end
        checks++; if (s_out_idx !== 4'hF) begin errors++; $display("FAIL midrst_idx: got %0h expected f", s_out_idx); end
        checks++; if (s_in_ready !== 1'b0) begin errors++; $display("FAIL midrst_in_ready: got %b expected 0", s_in_ready); end
        rst = 1'b0;
        tick_n(3);
        checks++; if (s_out_valid !== 1'b0) begin errors++; $display("FAIL midrst_no_result: got %b expected 0", s_out_valid); end
        send_frame(v, NC, 1'b1);
        checks++; if (s_out_idx !== 4'd2) begin errors++; $display("FAIL carry_idx: got %0d expected 2", s_out_idx); end
        checks++; if (s_out_max !== 26'd9) begin errors++; $display("FAIL carry_max: got %0d expected 9", s_out_max); end
        checks++; if (s_out_margin !== 27'd0) begin errors++; $display("FAIL carry_margin: got %0d expected 0", s_out_margin); end
        rst = 1'b1;
        tick_n(1);
        checks++; if (s_out_valid !== 1'b0) begin errors++; $display("FAIL holdrst_valid: got %b expected 0", s_out_valid); end
        checks++; if (s_out_max !== '0) begin errors++; $display("FAIL holdrst_max: got %0h expected 0", s_out_max); end
        rst = 1'b0;
        tick_n(1);
    endtask

    task automatic test_random();
        for (int f = 0; f < 1000; f++) begin
            int len, sidx, uidx;
            bit use_last, exp_err;
            longint sb, ss, ub, us, sv, uv;
            logic [DW-1:0] d;
            logic [DW:0] sm, um;
            len      = $urandom_range(1, NC);
            use_last = (len < NC) ? 1'b1 : 1'($urandom_range(0, 1));
            exp_err  = (len < NC) || !use_last;
            sb = 0; ss = 0; ub = 0; us = 0; sidx = 0; uidx = 0;
            for (int i = 0; i < len; i++) begin
                if ($urandom_range(0, 3) == 0) d = DW'($urandom());
                else d = DW'(int'($urandom_range(0, 16)) - 8);
                sv = longint'($signed(d));
                uv = longint'(d);
                if (i == 0) begin
                    sb = sv; ss = -(longint'(1) << (DW - 1)); sidx = 0;
                    ub = uv; us = 0; uidx = 0;
                end else begin
                    if (sv > sb) begin ss = sb; sb = sv; sidx = i; end
                    else if (sv > ss) ss = sv;
                    if (uv > ub) begin us = ub; ub = uv; uidx = i; end
                    else if (uv > us) us = uv;
                end
                if ($urandom_range(0, 3) == 0) tick_n($urandom_range(1, 3));
                send(d, use_last && (i == len - 1));
            end
            wait_valid(5);
            sm = (DW+1)'(sb - ss);
            um = (DW+1)'(ub - us);
            tick_n($urandom_range(0, 3));
            checks++; if (s_out_idx !== IW'(sidx)) begin errors++; $display("FAIL rnd_s_idx f%0d: got %0d expected %0d", f, s_out_idx, sidx); end
            checks++; if (s_out_max !== DW'(sb)) begin errors++; $display("FAIL rnd_s_max f%0d: got %0h expected %0h", f, s_out_max, DW'(sb)); end
            checks++; if (s_out_margin !== sm) begin errors++; $display("FAIL rnd_s_margin f%0d: got %0h expected %0h", f, s_out_margin, sm); end
            checks++; if (s_out_err !== exp_err) begin errors++; $display("FAIL rnd_s_err f%0d: got %b expected %b", f, s_out_err, exp_err); end
            checks++; if (u_out_idx !== IW'(uidx)) begin errors++; $display("FAIL rnd_u_idx f%0d: got %0d expected %0d", f, u_out_idx, uidx); end
            checks++; if (u_out_max !== DW'(ub)) begin errors++; $display("FAIL rnd_u_max f%0d: got %0h expected %0h", f, u_out_max, DW'(ub)); end
            checks++; if (u_out_margin !== um) begin errors++; $display("FAIL rnd_u_margin f%0d: got %0h expected %0h", f, u_out_margin, um); end
            release_result();
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_signed_unsigned();
        test_framing();
        test_backpressure();
        test_reset_midframe();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
